// File: rtl/plaintext_encrypter.sv
// Streaming character encrypter: latches a public key, then maps each plaintext
// character to (pt - key) mod P in the range 1..P through a one-deep output register.
module plaintext_encrypter #(
  parameter int         P         = 227,
  parameter logic [7:0] NULL_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [7:0]  public_key,
  input  logic        key_valid,
  input  logic [7:0]  pt_char,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  ct_char,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        err_invalid_key,
  output logic        err_invalid_char,
  output logic [15:0] char_count,
  output logic        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; ct_char/ct_valid hold while ct_valid && !ct_ready.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] KEYED = 1'b1;
  localparam logic [8:0] P9    = 9'(P);

  logic [0:0]  state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  ct_char_q, ct_char_d;
  logic        ct_valid_q, ct_valid_d;
  logic        err_key_q, err_key_d;
  logic        err_char_q, err_char_d;
  logic [15:0] count_q, count_d;

  logic        mode_enc;
  logic        key_ok;
  logic        char_ok;
  logic        accept;
  logic        pop;
  logic [8:0]  diff_raw;
  logic [8:0]  diff_adj;

  assign mode_enc = (mode == 2'b00);
  assign key_ok   = (public_key != 8'h00) && ({1'b0, public_key} < P9);
  assign char_ok  = (pt_char != 8'h00) && ({1'b0, pt_char} < P9);
  assign pop      = ct_valid_q && ct_ready;
  assign pt_ready = (state_q == KEYED) && mode_enc && (!ct_valid_q || ct_ready);
  assign accept   = pt_valid && pt_ready;

  // A non-positive difference folds to the top of the range, so 0 maps to P.
  always_comb begin
    diff_raw = {1'b0, pt_char} - {1'b0, key_q};
    if ($signed(diff_raw) <= 9'sd0) diff_adj = diff_raw + P9;
    else                            diff_adj = diff_raw;
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    err_key_d = key_valid && !key_ok;
    case (state_q)
      IDLE: begin
        if (key_valid && mode_enc && key_ok) begin
          state_d = KEYED;
          key_d   = public_key;
        end
      end
      KEYED: begin
        if (!mode_enc) begin
          state_d = IDLE;
          key_d   = 8'h00;
        end else if (key_valid && key_ok) begin
          key_d = public_key;
        end
      end
      default: begin
        state_d = IDLE;
        key_d   = 8'h00;
      end
    endcase
  end

  // The accepted character is encrypted with key_q, i.e. the key before any same-cycle reload.
  always_comb begin
    ct_char_d  = ct_char_q;
    ct_valid_d = ct_valid_q;
    err_char_d = 1'b0;
    count_d    = count_q;
    if (pop) begin
      ct_char_d  = NULL_CHAR;
      ct_valid_d = 1'b0;
      count_d    = count_q + 16'd1;
    end
    if (accept) begin
      if (char_ok) begin
        ct_char_d  = diff_adj[7:0];
        ct_valid_d = 1'b1;
      end else begin
        err_char_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 8'h00;
      ct_char_q  <= NULL_CHAR;
      ct_valid_q <= 1'b0;
      err_key_q  <= 1'b0;
      err_char_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      ct_char_q  <= ct_char_d;
      ct_valid_q <= ct_valid_d;
      err_key_q  <= err_key_d;
      err_char_q <= err_char_d;
      count_q    <= count_d;
    end
  end

  assign ct_char          = ct_char_q;
  assign ct_valid         = ct_valid_q;
  assign err_invalid_key  = err_key_q;
  assign err_invalid_char = err_char_q;
  assign char_count       = count_q;
  assign state_dbg        = state_q[0];

endmodule
